tlul_host_bridge: RTL and testbench

- Initiator-side TL-UL bridge.
- Converts a simple core-style request/grant memory port (req/gnt/we/addr/wdata/be, with rvalid/rdata/err responses) into TL-UL A-channel requests.
- Returns D-channel responses to the core, in order.
- Sits between a processor data/instruction port and the TL-UL crossbar, and drives memory-mapped responders such as the data and instruction memories.
- Tracks outstanding transactions, tags them with rotating source IDs and flags protocol errors.

---
 rtl/tlul_pkg.sv | 44 ++++
 rtl/tlul_host_bridge.sv | 176 +++++++++++++++++
 tb/tb_tlul_host_bridge.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlul_pkg.sv
// TL-UL channel structures and opcode constants shared by hosts and devices.
// Bus is 32-bit data, 32-bit address, 8-bit source.
package tlul_pkg;

   localparam int AddrW = 32;
   localparam int DataW = 32;
   localparam int MaskW = DataW / 8;
   localparam int SrcW  = 8;
   localparam int UserW = 16;

   localparam logic [2:0] PutFullData    = 3'h0;
   localparam logic [2:0] PutPartialData = 3'h1;
   localparam logic [2:0] Get            = 3'h4;

   localparam logic [2:0] AccessAck      = 3'h0;
   localparam logic [2:0] AccessAckData  = 3'h1;

   typedef struct packed {
      logic             a_valid;
      logic [2:0]       a_opcode;
      logic [2:0]       a_param;
      logic [1:0]       a_size;
      logic [SrcW-1:0]  a_source;
      logic [AddrW-1:0] a_address;
      logic [MaskW-1:0] a_mask;
      logic [DataW-1:0] a_data;
      logic [UserW-1:0] a_user;
      logic             d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic             d_valid;
      logic [2:0]       d_opcode;
      logic [2:0]       d_param;
      logic [1:0]       d_size;
      logic [SrcW-1:0]  d_source;
      logic             d_sink;
      logic [DataW-1:0] d_data;
      logic [UserW-1:0] d_user;
      logic             d_error;
      logic             a_ready;
   } tl_d2h_t;

endpackage

// File: rtl/tlul_host_bridge.sv
// Core req/gnt memory port to TL-UL host bridge: one registered A beat,
// in-order D responses reported one cycle after the beat, tag/opcode checks.
module tlul_host_bridge #(
   parameter int MaxOutstanding = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req_i,
   output logic                 gnt_o,
   input  logic                 we_i,
   input  logic [31:0]          addr_i,
   input  logic [31:0]          wdata_i,
   input  logic [3:0]           be_i,
   output logic                 rvalid_o,
   output logic [31:0]          rdata_o,
   output logic                 err_o,
   output tlul_pkg::tl_h2d_t    tl_h_o,
   input  tlul_pkg::tl_d2h_t    tl_h_i
);

   localparam int TagW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int CntW = $clog2(MaxOutstanding + 1);
   localparam int SrcW = tlul_pkg::SrcW;
   localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
   localparam logic [TagW-1:0] TagLast = TagW'(MaxOutstanding - 1);

   function automatic logic [TagW-1:0] tag_inc(input logic [TagW-1:0] t);
      return (t == TagLast) ? '0 : t + TagW'(1);
   endfunction

   // A-channel holding register
   logic        a_valid_q;
   logic [2:0]  a_opcode_q;
   logic [29:0] a_word_q;
   logic [3:0]  a_mask_q;
   logic [31:0] a_data_q;
   logic [TagW-1:0] a_source_q;

   // Transaction tracking
   logic [CntW-1:0]           out_cnt_q;
   logic [TagW-1:0]           issue_tag_q;
   logic [TagW-1:0]           exp_tag_q;
   logic [MaxOutstanding-1:0] we_q;

   // Response register
   logic        rvalid_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        cnt_ok;
   logic        a_free;
   logic        d_resp;
   logic [2:0]  a_opcode_d;
   logic [3:0]  a_mask_d;
   logic [31:0] a_data_d;
   logic [SrcW-1:0] exp_src;
   logic [2:0]  exp_opcode;
   logic        resp_err;
   logic [31:0] resp_data;

   // Handshakes: a core request is taken when req_i && gnt_o in the same
   // cycle; an A beat completes when a_valid && a_ready are both sampled
   // high; every D beat is accepted because d_ready is constantly 1.
   assign cnt_ok = (out_cnt_q < CntMax);
   assign a_free = !a_valid_q || tl_h_i.a_ready;
   assign gnt_o  = !reset && req_i && cnt_ok && a_free;

   // Spurious D beats (nothing outstanding) are dropped entirely.
   assign d_resp = tl_h_i.d_valid && (out_cnt_q != '0);

   always_comb begin
      a_opcode_d = tlul_pkg::Get;
      a_mask_d   = 4'hF;
      a_data_d   = '0;
      if (we_i) begin
         a_data_d = wdata_i;
         if (be_i == 4'hF) begin
            a_opcode_d = tlul_pkg::PutFullData;
         end else begin
            a_opcode_d = tlul_pkg::PutPartialData;
            a_mask_d   = be_i;
         end
      end
   end

   always_comb begin
      exp_src    = {{(SrcW - TagW){1'b0}}, exp_tag_q};
      exp_opcode = we_q[exp_tag_q] ? tlul_pkg::AccessAck : tlul_pkg::AccessAckData;
      resp_err   = tl_h_i.d_error
                 || (tl_h_i.d_source != exp_src)
                 || (tl_h_i.d_opcode != exp_opcode);
      resp_data  = (tl_h_i.d_opcode == tlul_pkg::AccessAckData) ? tl_h_i.d_data : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         a_valid_q  <= 1'b0;
         a_opcode_q <= '0;
         a_word_q   <= '0;
         a_mask_q   <= '0;
         a_data_q   <= '0;
         a_source_q <= '0;
      end else if (gnt_o) begin
         a_valid_q  <= 1'b1;
         a_opcode_q <= a_opcode_d;
         a_word_q   <= addr_i[31:2];
         a_mask_q   <= a_mask_d;
         a_data_q   <= a_data_d;
         a_source_q <= issue_tag_q;
      end else if (tl_h_i.a_ready) begin
         a_valid_q  <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         issue_tag_q <= '0;
         we_q        <= '0;
      end else if (gnt_o) begin
         issue_tag_q       <= tag_inc(issue_tag_q);
         we_q[issue_tag_q] <= we_i;
      end
   end

   // Grant and response in the same cycle leave the count unchanged.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_cnt_q <= '0;
      end else begin
         case ({gnt_o, d_resp})
            2'b10:   out_cnt_q <= out_cnt_q + CntW'(1);
            2'b01:   out_cnt_q <= out_cnt_q - CntW'(1);
            default: out_cnt_q <= out_cnt_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         exp_tag_q <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         rvalid_q <= d_resp;
         rdata_q  <= d_resp ? resp_data : '0;
         err_q    <= d_resp && resp_err;
         if (d_resp) begin
            exp_tag_q <= tag_inc(exp_tag_q);
         end
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;

   always_comb begin
      tl_h_o           = '0;
      tl_h_o.a_valid   = a_valid_q;
      tl_h_o.a_opcode  = a_opcode_q;
      tl_h_o.a_param   = 3'h0;
      tl_h_o.a_size    = 2'd2;
      tl_h_o.a_source  = {{(SrcW - TagW){1'b0}}, a_source_q};
      tl_h_o.a_address = {a_word_q, 2'b00};
      tl_h_o.a_mask    = a_mask_q;
      tl_h_o.a_data    = a_data_q;
      tl_h_o.a_user    = '0;
      tl_h_o.d_ready   = 1'b1;
   end

   logic unused_inputs;
   assign unused_inputs = ^{addr_i[1:0], tl_h_i.d_param, tl_h_i.d_size,
                            tl_h_i.d_sink, tl_h_i.d_user};

endmodule

// File: tb/tb_tlul_host_bridge.sv
// Directed bench for tlul_host_bridge: the bench plays the TL-UL responder,
// queues the response each D beat should produce and checks rvalid_o pulses.
module tb_tlul_host_bridge;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_i = 1'b0;
   logic        gnt_o;
   logic        we_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic [3:0]  be_i = '0;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   tlul_pkg::tl_h2d_t tl_h_o;
   tlul_pkg::tl_d2h_t tl_h_i;

   int n_vec = 0;
   int n_err = 0;
   logic [32:0] exp_q[$];

   tlul_host_bridge #(.MaxOutstanding(2)) dut (
      .clock    (clock),
      .reset    (reset),
      .req_i    (req_i),
      .gnt_o    (gnt_o),
      .we_i     (we_i),
      .addr_i   (addr_i),
      .wdata_i  (wdata_i),
      .be_i     (be_i),
      .rvalid_o (rvalid_o),
      .rdata_o  (rdata_o),
      .err_o    (err_o),
      .tl_h_o   (tl_h_o),
      .tl_h_i   (tl_h_i)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_i = 1'b0;
      tl_h_i = '0;
      tl_h_i.a_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Drive one core request, expect an immediate grant, then drop req_i.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input string tag);
      req_i = 1'b1;
      we_i = we;
      addr_i = addr;
      wdata_i = wd;
      be_i = be;
      #1;
      check({tag, ".gnt"}, gnt_o, 1);
      tick();
      req_i = 1'b0;
   endtask

   task automatic check_a(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] data, input logic [7:0] src, input string tag);
      check({tag, ".a_valid"}, tl_h_o.a_valid, 1);
      check({tag, ".a_opcode"}, tl_h_o.a_opcode, op);
      check({tag, ".a_address"}, tl_h_o.a_address, addr);
      check({tag, ".a_mask"}, tl_h_o.a_mask, mask);
      check({tag, ".a_data"}, tl_h_o.a_data, data);
      check({tag, ".a_source"}, tl_h_o.a_source, src);
      check({tag, ".a_fixed"}, {tl_h_o.a_size, tl_h_o.a_param, tl_h_o.a_user, tl_h_o.d_ready},
            {2'd2, 3'd0, 16'd0, 1'b1});
   endtask

   // One D beat; the response it must produce is queued for the monitor.
   task automatic send_d(input logic [2:0] op, input logic [7:0] src, input logic [31:0] data,
                         input logic derr, input logic exp_err, input logic [31:0] exp_data,
                         input string tag);
      tl_h_i.d_valid = 1'b1;
      tl_h_i.d_opcode = op;
      tl_h_i.d_source = src;
      tl_h_i.d_data = data;
      tl_h_i.d_error = derr;
      exp_q.push_back({exp_err, exp_data});
      tick();
      check({tag, ".rvalid"}, rvalid_o, 1);
      tl_h_i.d_valid = 1'b0;
      tl_h_i.d_error = 1'b0;
   endtask

   always @(negedge clock) begin
      if (rvalid_o) begin
         if (exp_q.size() == 0) begin
            check("resp.unexpected", rvalid_o, 0);
         end else begin
            check("resp.err_data", {err_o, rdata_o}, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tl_h_i = '0;
      tl_h_i.a_ready = 1'b1;

      // Reset: grant forced low, all state cleared
      reset = 1'b1;
      req_i = 1'b1;
      #1;
      check("rst.gnt", gnt_o, 0);
      do_reset();
      check("rst.a_valid", tl_h_o.a_valid, 0);
      check("rst.a_fields", {tl_h_o.a_opcode, tl_h_o.a_address, tl_h_o.a_mask, tl_h_o.a_data}, 0);
      check("rst.resp", {rvalid_o, err_o, rdata_o}, 0);
      check("rst.out_cnt", dut.out_cnt_q, 0);

      // Single read
      issue(1'b0, 32'h0000_1006, 32'h0, 4'h0, "rd");
      check_a(3'd4, 32'h0000_1004, 4'hF, 32'h0, 8'd0, "rd");
      tick();
      check("rd.a_done", tl_h_o.a_valid, 0);
      send_d(3'd1, 8'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, "rd");
      tick();
      check("rd.pulse", rvalid_o, 0);

      // Partial and full writes
      issue(1'b1, 32'h0000_2000, 32'hA5A5_0000, 4'b1100, "pw");
      check_a(3'd1, 32'h0000_2000, 4'b1100, 32'hA5A5_0000, 8'd1, "pw");
      tick();
      send_d(3'd0, 8'd1, 32'h0, 1'b0, 1'b0, 32'h0, "pw");
      issue(1'b1, 32'h0000_2004, 32'h1234_5678, 4'hF, "fw");
      check_a(3'd0, 32'h0000_2004, 4'hF, 32'h1234_5678, 8'd0, "fw");
      tick();
      send_d(3'd0, 8'd0, 32'h0, 1'b0, 1'b0, 32'h0, "fw");
      tick();

      // Outstanding limit with stalled D channel
      do_reset();
      req_i = 1'b1;
      we_i = 1'b0;
      addr_i = 32'h0000_3000;
      #1;
      check("lim.gnt0", gnt_o, 1);
      tick();
      addr_i = 32'h0000_3004;
      #1;
      check("lim.gnt1", gnt_o, 1);
      check("lim.src0", tl_h_o.a_source, 0);
      tick();
      addr_i = 32'h0000_3008;
      #1;
      check("lim.gnt2_blocked", gnt_o, 0);
      check("lim.src1", tl_h_o.a_source, 1);
      tick();
      check("lim.still_blocked", gnt_o, 0);
      check("lim.out_cnt", dut.out_cnt_q, 2);
      tl_h_i.d_valid = 1'b1;
      tl_h_i.d_opcode = 3'd1;
      tl_h_i.d_source = 8'd0;
      tl_h_i.d_data = 32'h1111_1111;
      exp_q.push_back({1'b0, 32'h1111_1111});
      #1;
      check("lim.gnt_during_d", gnt_o, 0);
      tick();
      tl_h_i.d_valid = 1'b0;
      check("lim.rvalid", rvalid_o, 1);
      #1;
      check("lim.regrant", gnt_o, 1);
      tick();
      req_i = 1'b0;
      check_a(3'd4, 32'h0000_3008, 4'hF, 32'h0, 8'd0, "lim3");
      tick();
      send_d(3'd1, 8'd1, 32'h2222_2222, 1'b0, 1'b0, 32'h2222_2222, "lim.r1");
      send_d(3'd1, 8'd0, 32'h3333_3333, 1'b0, 1'b0, 32'h3333_3333, "lim.r2");
      tick();
      check("lim.drained", dut.out_cnt_q, 0);

      // A backpressure: fields held, no second grant while full
      tl_h_i.a_ready = 1'b0;
      issue(1'b0, 32'h0000_4000, 32'h0, 4'h0, "bp");
      req_i = 1'b1;
      we_i = 1'b1;
      addr_i = 32'h0000_4010;
      wdata_i = 32'hCAFE_F00D;
      be_i = 4'hF;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("bp.no_gnt", gnt_o, 0);
         check_a(3'd4, 32'h0000_4000, 4'hF, 32'h0, 8'd1, "bp.hold");
         tick();
      end
      tl_h_i.a_ready = 1'b1;
      #1;
      check("bp.regrant", gnt_o, 1);
      tick();
      req_i = 1'b0;
      check_a(3'd0, 32'h0000_4010, 4'hF, 32'hCAFE_F00D, 8'd0, "bp.next");
      tick();
      send_d(3'd1, 8'd1, 32'h4444_4444, 1'b0, 1'b0, 32'h4444_4444, "bp.r0");
      send_d(3'd0, 8'd0, 32'h0, 1'b0, 1'b0, 32'h0, "bp.r1");
      tick();

      // Error reporting
      do_reset();
      issue(1'b0, 32'h0000_5000, 32'h0, 4'h0, "e_derr");
      tick();
      send_d(3'd1, 8'd0, 32'h5555_5555, 1'b1, 1'b1, 32'h5555_5555, "e_derr");
      issue(1'b0, 32'h0000_5004, 32'h0, 4'h0, "e_src");
      tick();
      send_d(3'd1, 8'd0, 32'h6666_6666, 1'b0, 1'b1, 32'h6666_6666, "e_src");
      issue(1'b0, 32'h0000_5008, 32'h0, 4'h0, "e_rdop");
      tick();
      send_d(3'd0, 8'd0, 32'h7777_7777, 1'b0, 1'b1, 32'h0, "e_rdop");
      issue(1'b1, 32'h0000_500C, 32'h0000_00AB, 4'b0011, "e_wrop");
      tick();
      send_d(3'd1, 8'd1, 32'h8888_8888, 1'b0, 1'b1, 32'h8888_8888, "e_wrop");
      tick();
      tl_h_i.d_valid = 1'b1;
      tl_h_i.d_opcode = 3'd1;
      tl_h_i.d_source = 8'd0;
      tl_h_i.d_data = 32'h9999_0000;
      tick();
      tl_h_i.d_valid = 1'b0;
      check("spur.rvalid", rvalid_o, 0);
      check("spur.out_cnt", dut.out_cnt_q, 0);
      issue(1'b0, 32'h0000_5010, 32'h0, 4'h0, "post_spur");
      check("post_spur.src", tl_h_o.a_source, 0);
      tick();
      send_d(3'd1, 8'd0, 32'h9999_9999, 1'b0, 1'b0, 32'h9999_9999, "post_spur");
      tick();

      // Reset with two outstanding and a_valid high
      issue(1'b0, 32'h0000_6000, 32'h0, 4'h0, "mid0");
      issue(1'b0, 32'h0000_6004, 32'h0, 4'h0, "mid1");
      tl_h_i.a_ready = 1'b0;
      check("mid.a_valid", tl_h_o.a_valid, 1);
      check("mid.out_cnt", dut.out_cnt_q, 2);
      reset = 1'b1;
      tick();
      check("mid.rst_a_valid", tl_h_o.a_valid, 0);
      check("mid.rst_rvalid", rvalid_o, 0);
      check("mid.rst_out_cnt", dut.out_cnt_q, 0);
      reset = 1'b0;
      tl_h_i.a_ready = 1'b1;
      tl_h_i.d_valid = 1'b1;
      tl_h_i.d_opcode = 3'd1;
      tl_h_i.d_source = 8'd0;
      tl_h_i.d_data = 32'hBAD0_BAD0;
      tick();
      tl_h_i.d_valid = 1'b0;
      check("late.rvalid", rvalid_o, 0);
      check("late.out_cnt", dut.out_cnt_q, 0);
      tick();
      tick();

      check("queue.empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
